des_stream_ctrl: RTL
====================

Name: des_stream_ctrl

Overview:
- Byte-stream front/back end for the DES core, instantiated directly around it.
- Upstream role: assembles 8-byte key and data blocks from a valid/ready byte stream and drives the core's load, key_in and data_in.
- Downstream role: waits the core's fixed latency, captures data_out and serialises the 64-bit result as 8 bytes on a valid/ready output stream.
- Single-block-in-flight ECB controller.

Parameters:
- DES_LATENCY, 2, edges from the des_load-high edge until des_result is valid (input register plus output register of the core).
- BLOCK_BYTES, 8, bytes per block; fixed at 8, present only for the shared package constant.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; every flop clears on the edge where reset=1.
- in_byte  in  8  input stream byte.
- in_key  in  1  1 = block is a key block; sampled only on byte 0 of a block.
- in_valid  in  1  input byte valid.
- in_ready  out  1  controller accepts in_byte this cycle.
- out_byte  out  8  output ciphertext byte.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  sink accepts out_byte.
- des_load  out  1  one-cycle load strobe to the DES core.
- des_key  out  64  key to the DES core (key_in).
- des_data  out  64  plaintext block to the DES core (data_in).
- des_result  in  64  DES core data_out.
- key_loaded  out  1  a complete key block has been received since reset.
- err_nokey  out  1  one-cycle pulse: a data byte was dropped because no key is loaded.
- busy  out  1  high in LOAD, WAIT and EMIT states.

Behaviour:
- Reset values: all outputs 0. Key shadow, block register, output shift register, byte counter and wait counter all 0. FSM returns to COLLECT.
- Byte order: MSB first. Byte 0 goes to bits [63:56], byte 7 to bits [7:0]. Output uses the same order.
- Handshake: a transfer occurs on an edge where valid=1 and ready=1.
  - in_ready = 1 only in COLLECT.
  - Once out_valid=1, out_byte and out_valid stay stable until out_ready=1.
- FSM states: COLLECT, LOAD, WAIT, EMIT.
- COLLECT:
  - 3-bit byte counter increments per accepted byte.
  - On byte 0, in_key is latched as blk_is_key. in_key on bytes 1-7 is ignored.
  - On byte 7 the counter wraps 7 -> 0.
    - If blk_is_key: the assembled block is written to the key shadow, key_loaded is set, and the FSM stays in COLLECT. A new key block overwrites the old key.
    - Else: go to LOAD.
  - Data byte accepted while key_loaded=0: the byte is consumed (in_ready stays 1), err_nokey pulses for 1 cycle, the counter does not advance, and no block is assembled.
- LOAD:
  - des_load=1 for exactly one cycle. des_key = key shadow, des_data = assembled block; both held stable from LOAD until the next LOAD.
  - Next state: WAIT, with the wait counter cleared.
- WAIT:
  - Wait counter increments each cycle.
  - des_result is sampled on the edge DES_LATENCY edges after the LOAD edge (with default 2: the LOAD edge, plus one WAIT edge), loaded into the output shift register, then go to EMIT.
- EMIT:
  - out_valid=1 with out_byte = shift register [63:56].
  - On each transfer, shift left 8 and increment the counter.
  - The transfer of byte 7 clears out_valid in the same edge and returns the FSM to COLLECT; the counter wraps to 0.
  - out_ready=0 stalls indefinitely with no data loss.
- Throughput: 8 in + 1 LOAD + (DES_LATENCY-1) WAIT + 8 out cycles per block with no stalls; no overlap of input and output.
- Reset mid-operation: the partial input block, in-flight result and partial output block are discarded. key_loaded clears, so a new key must be sent.
- Simultaneous events:
  - in_valid is ignored outside COLLECT.
  - reset has priority over every transfer in the same cycle.
- busy = (state != COLLECT).

Decomposition:
- Shared package des_pkg:
  - BLOCK_BYTES=8, DES_LATENCY=2.
  - FSM state enum/localparams (COLLECT, LOAD, WAIT, EMIT).
  - Byte-lane index helper constants.
- One natural sub-module: des_byte_serializer, covering the output shift register, counter and out_valid/out_ready handshake. Input assembly stays inline.

Test Plan:
- Key block 13 34 57 79 9B BC DF F1 (in_key=1), then data 01 23 45 67 89 AB CD EF -> key_loaded=1; single des_load with des_key=133457799BBCDFF1, des_data=0123456789ABCDEF; out bytes 85 E8 13 54 0F 0A B4 05.
- Key 0E329232EA6D0D73, data 8787878787878787 -> out bytes 00 00 00 00 00 00 00 00; des_load high exactly once; out_valid rises DES_LATENCY cycles after des_load.
- After reset, send data byte 11 with no key -> err_nokey pulses once per byte, no des_load, byte counter stays 0, key_loaded=0.
- Hold out_ready=0 for 5 cycles at output byte 3 -> out_byte stays at byte 3 value, out_valid stays 1, in_ready=0; on release the remaining bytes are emitted in order.
- Assert reset during EMIT at byte 4 -> next cycle out_valid=0, busy=0, key_loaded=0; following data block produces err_nokey.
- Key block sent with in_key toggled on bytes 3-7 -> whole block treated as key (byte-0 value); a second key block replaces the first, and the next data block uses the new des_key.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants and FSM encoding for the DES byte-stream controller.
// Byte lanes are MSB first: byte 0 occupies the top lane of a 64-bit block.
package des_pkg;

  localparam int BLOCK_BYTES = 8;
  localparam int DES_LATENCY = 2;
  localparam int BYTE_W      = 8;
  localparam int BLOCK_W     = BLOCK_BYTES * BYTE_W;

  // Lane helpers: first/last byte index and the bit position of the top lane.
  localparam logic [2:0] FIRST_BYTE  = 3'd0;
  localparam logic [2:0] LAST_BYTE   = 3'(BLOCK_BYTES - 1);
  localparam int         MSB_LANE_LO = BLOCK_W - BYTE_W;

  // DES_LATENCY edges from the LOAD edge: the LOAD edge plus DES_LATENCY-1 WAIT edges.
  localparam int               WAIT_W    = 4;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DES_LATENCY - 2);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_EMIT    = 2'd3
  } des_state_e;

endpackage

// File: rtl/des_stream_ctrl_if.sv
// Byte-stream input and output channels of the DES controller.
// valid/ready: a byte moves on a rising edge where valid=1 and ready=1; once the
// source raises valid, byte and valid stay unchanged until that transfer edge.
interface des_stream_ctrl_if;
  logic [7:0] in_byte;
  logic       in_key;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_byte, in_key, in_valid, out_ready,
    input  in_ready, out_byte, out_valid
  );

  modport slave (
    input  in_byte, in_key, in_valid, out_ready,
    output in_ready, out_byte, out_valid
  );
endinterface

// File: rtl/des_byte_serializer.sv
// Output shift register: loads a 64-bit result and emits it MSB byte first
// on a valid/ready stream, stalling indefinitely while ready is low.
module des_byte_serializer
  import des_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [BLOCK_W-1:0] data_i,
  output logic [BYTE_W-1:0]  out_byte_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               done_o
);

  logic [BLOCK_W-1:0] sh_q, sh_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               fire;

  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    fire    = valid_q && out_ready_i;
    done_o  = fire && (cnt_q == LAST_BYTE);

    if (load_i) begin
      sh_d    = data_i;
      cnt_d   = FIRST_BYTE;
      valid_d = 1'b1;
    end else if (fire) begin
      sh_d  = {sh_q[MSB_LANE_LO-1:0], {BYTE_W{1'b0}}};
      cnt_d = cnt_q + 3'd1;
      // Last byte leaves on this edge; the counter wraps naturally to 0.
      if (cnt_q == LAST_BYTE) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign out_byte_o  = sh_q[BLOCK_W-1:MSB_LANE_LO];
  assign out_valid_o = valid_q;

endmodule

// File: rtl/des_stream_ctrl.sv
// Single-block-in-flight ECB controller around the DES core: assembles key and
// data blocks from a byte stream, loads the core, and serialises the result.
module des_stream_ctrl
  import des_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  des_stream_ctrl_if.slave   s,
  output logic               des_load,
  output logic [BLOCK_W-1:0] des_key,
  output logic [BLOCK_W-1:0] des_data,
  input  logic [BLOCK_W-1:0] des_result,
  output logic               key_loaded,
  output logic               err_nokey,
  output logic               busy,
  output des_state_e         dbg_state_o
);

  des_state_e         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               blk_is_key_q, blk_is_key_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic               key_loaded_q, key_loaded_d;
  logic               err_q, err_d;
  logic [BLOCK_W-1:0] dkey_q, dkey_d;
  logic [BLOCK_W-1:0] ddata_q, ddata_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               is_key;
  logic               ser_load;
  logic               ser_done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    blk_is_key_d = blk_is_key_q;
    blk_d        = blk_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    err_d        = 1'b0;
    dkey_d       = dkey_q;
    ddata_d      = ddata_q;
    wait_d       = wait_q;
    ser_load     = 1'b0;
    is_key       = (cnt_q == FIRST_BYTE) ? s.in_key : blk_is_key_q;

    unique case (state_q)
      ST_COLLECT: begin
        if (s.in_valid) begin
          // A data block cannot start without a key: drop the byte, stay at byte 0.
          if (!is_key && !key_loaded_q) begin
            err_d = 1'b1;
          end else begin
            blk_d = {blk_q[BLOCK_W-BYTE_W-1:0], s.in_byte};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == FIRST_BYTE) blk_is_key_d = s.in_key;
            if (cnt_q == LAST_BYTE) begin
              if (is_key) begin
                key_d        = blk_d;
                key_loaded_d = 1'b1;
              end else begin
                // Core inputs change only here, so they hold from LOAD to the next LOAD.
                dkey_d  = key_q;
                ddata_d = blk_d;
                state_d = ST_LOAD;
              end
            end
          end
        end
      end
      ST_LOAD: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_LAST) begin
          ser_load = 1'b1;
          state_d  = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (ser_done) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_COLLECT;
      cnt_q        <= '0;
      blk_is_key_q <= 1'b0;
      blk_q        <= '0;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      err_q        <= 1'b0;
      dkey_q       <= '0;
      ddata_q      <= '0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      blk_is_key_q <= blk_is_key_d;
      blk_q        <= blk_d;
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      err_q        <= err_d;
      dkey_q       <= dkey_d;
      ddata_q      <= ddata_d;
      wait_q       <= wait_d;
    end
  end

  des_byte_serializer u_ser (
    .clk         (clk),
    .reset       (reset),
    .load_i      (ser_load),
    .data_i      (des_result),
    .out_byte_o  (s.out_byte),
    .out_valid_o (s.out_valid),
    .out_ready_i (s.out_ready),
    .done_o      (ser_done)
  );

  assign s.in_ready   = (state_q == ST_COLLECT);
  assign des_load     = (state_q == ST_LOAD);
  assign des_key      = dkey_q;
  assign des_data     = ddata_q;
  assign key_loaded   = key_loaded_q;
  assign err_nokey    = err_q;
  assign busy         = (state_q != ST_COLLECT);
  assign dbg_state_o  = state_q;

endmodule
